// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store access controller with req/ack bus, lane steering and load extension.
// Optional bus-timeout abort enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        err_cause,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_cause_q, err_cause_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        sgn_q, sgn_d;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic [31:0] lane;
    logic [31:0] fmt;

`ifdef LSU_TIMEOUT_EN
    logic [9:0] cnt_q, cnt_d;

    assign cnt_d   = (state_q == REQ) ? cnt_q + 10'd1 : 10'd0;
    assign timeout = (cnt_d == 10'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    // size 11 behaves as word everywhere via req_size[1]
    assign misaligned = (req_size == 2'b01 & addr[0]) | (req_size[1] & |addr[1:0]);
    assign be_in = (req_size == 2'b00) ? 4'b0001 << addr[1:0] :
                   (req_size == 2'b01) ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    assign wd_in = (req_size == 2'b00) ? {4{wdata[7:0]}} :
                   (req_size == 2'b01) ? {2{wdata[15:0]}} : wdata;
    assign lane  = bus_rdata >> {off_q, 3'b000};
    assign fmt   = (size_q == 2'b00) ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
                   (size_q == 2'b01) ? {{16{sgn_q & lane[15]}}, lane[15:0]} : bus_rdata;

    always_comb begin
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        err_cause_d = err_cause_q;
        size_d      = size_q;
        off_d       = off_q;
        sgn_d       = sgn_q;
        case (state_q)
            IDLE: if (req_valid) begin
                if (misaligned) begin
                    state_d     = ERR;
                    err_cause_d = 1'b0;
                end else begin
                    state_d     = REQ;
                    bus_we_d    = req_we;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_in;
                    bus_wdata_d = wd_in;
                    size_d      = req_size;
                    off_d       = addr[1:0];
                    sgn_d       = req_signed;
                end
            end
            REQ: if (bus_ack) begin
                state_d = DONE;
                if (!bus_we_q) load_data_d = fmt;
            end else if (timeout) begin
                state_d     = ERR;
                err_cause_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            load_data_q <= '0;
            err_cause_q <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            sgn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            err_cause_q <= err_cause_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sgn_q       <= sgn_d;
        end
    end

    assign bus_req   = (state_q == REQ);
    assign stall     = (state_q == IDLE & req_valid) | bus_req;
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign err_cause = err_cause_q;
    assign load_data = load_data_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store access controller directly downstream of the execute ALU in the single-cycle MIPS core. It consumes the ALU result as the effective address, runs one access on the data-memory bus with a req/ack handshake, and stalls the core until the access completes. It performs byte-lane steering, byte enables and load sign/zero extension, and flags misaligned accesses. The writeback mux receives `load_data`.

## Interface
- `TIMEOUT_CYCLES`, default 255: max `bus_req` cycles without ack before abort; only used with `LSU_TIMEOUT_EN`; range 1..1023.

- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  current instruction is a load or store; held until `stall` is low
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- `req_signed`  in  1  load sign-extends (LB/LH) when 1
- `addr`  in  32  effective address (ALU result)
- `wdata`  in  32  store data, right-aligned
- `stall`  out  1  freeze PC and register writes this cycle
- `done`  out  1  one-cycle pulse: access finished, `load_data` valid
- `err`  out  1  one-cycle pulse: access aborted
- `err_cause`  out  1  0 = misaligned, 1 = bus timeout; valid with `err`
- `load_data`  out  32  formatted load result; holds until the next load `done`
- `bus_req`  out  1  memory request
- `bus_we`  out  1  write strobe
- `bus_addr`  out  32  word address, {addr[31:2],2'b00}
- `bus_be`  out  4  byte enables, bit0 = addr byte 0 (little-endian)
- `bus_wdata`  out  32  lane-steered store data
- `bus_ack`  in  1  memory completes the request this cycle
- `bus_rdata`  in  32  read word, valid with `bus_ack`

## Operation
- States: IDLE, REQ, DONE, ERR. Reset → IDLE.
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `load_data`=0, `done`=0, `err`=0, `err_cause`=0. `stall` is 0 in IDLE with `req_valid`=0.
- IDLE, `req_valid`=1:
  - Aligned (half: addr[0]=0; word: addr[1:0]=0): register the bus outputs and go to REQ.
  - Misaligned: go to ERR with `err_cause`=0. The bus is never touched.
- REQ: `bus_req`=1. `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` stay stable until ack.
  - On `bus_ack`: capture formatted `bus_rdata` into `load_data` (loads only), then go to DONE.
- DONE: `done`=1, then IDLE unconditionally. The still-asserted `req_valid` of the finishing instruction is ignored.
- ERR: `err`=1, then IDLE unconditionally.
- `stall` = (IDLE & `req_valid`) | REQ. It is low in DONE and ERR.
- Byte enables:
  - Byte: `bus_be` = 0001 << addr[1:0].
  - Half: `bus_be` = 0011 << (2·addr[1]).
  - Word: `bus_be` = 1111.
  - Loads drive the same `bus_be`.
- Store data: byte is replicated to all four lanes, half to both halves, word unchanged.
- Load data: the lane selected by addr is right-aligned. It is sign-extended if `req_signed`, else zero-extended. Word loads ignore `req_signed`.
- A `bus_ack` seen outside REQ is ignored.
- A store leaves `load_data` unchanged.

## Timing
- Access with ack k cycles after entering REQ (k ≥ 0):
  - Cycle 0: IDLE accepts the request, `stall`=1.
  - Cycles 1..1+k: REQ, `stall`=1, with ack arriving in cycle 1+k.
  - Cycle 2+k: DONE.
  - Minimum load-to-done latency is 2 cycles, with `stall` high for 2 cycles.
- Misaligned access: `stall`=1 in cycle 0, `err` in cycle 1, 2 cycles total.
- `load_data` is registered and updates on the clock edge that enters DONE.
- Reset asserted mid-access: all outputs clear asynchronously and `bus_req` drops immediately. A pending access is abandoned, and a late `bus_ack` is ignored.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 10-bit counter clears on entering REQ and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the FSM drops `bus_req` and goes to ERR with `err_cause`=1.
  - An ack in the same cycle as the limit wins and the FSM goes to DONE.
- `LSU_TIMEOUT_EN` undefined: REQ waits indefinitely, the counter is not built, and `err_cause` is always 0.

## Test plan
- LW: addr=0x100 with immediate ack, `bus_rdata`=0xDEADBEEF → `bus_be`=1111, `stall` high 2 cycles, `done` in cycle 2, `load_data`=0xDEADBEEF.
- LB with `req_signed`=1, addr=0x103, `bus_rdata`=0x80112233 → `bus_be`=1000, `load_data`=0xFFFFFF80. LBU with the same inputs → 0x00000080.
- SH: addr=0x202, `wdata`=0x0000ABCD, ack delayed 3 cycles → `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_addr`=0x200, bus outputs stable for 4 REQ cycles, `done` in cycle 5.
- LW at addr=0x101 → `err`=1 with `err_cause`=0 in cycle 1, `bus_req` never asserted.
- Reset asserted during REQ, then a late `bus_ack` → all outputs 0 immediately, FSM stays in IDLE, no `done`.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → `bus_req` high 4 cycles, then `err`=1 with `err_cause`=1.
